pipe_stage_chain: RTL and testbench

Parametrised successor to the plain pass-through pipeline register. It is a clocked chain of DEPTH pipeline stages, each WIDTH bits wide, with a valid bit per stage. It has a global stall (hold) and a per-stage flush mask for branch/hazard squashing, and reports how many stages are occupied. It sits between MIPS pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) and is driven by the hazard unit.

---
 rtl/pipe_stage_chain_if.sv | 29 ++
 rtl/pipe_stage_chain.sv | 68 ++++++
 tb/tb_pipe_stage_chain.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Bundle of the data/control signals around one pipe_stage_chain instance.
//   master : producer / hazard unit side (drives in_*, stall, flush_mask)
//   slave  : the chain itself (drives out_*, occupancy, busy)
// WIDTH and DEPTH must match the chain instance that uses this bundle.
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
);
  localparam int OCC_W = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             stall;
  logic [DEPTH-1:0] flush_mask;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
  logic             busy;

  modport master (
    output in_valid, in_data, stall, flush_mask,
    input  out_valid, out_data, occupancy, busy
  );

  modport slave (
    input  in_valid, in_data, stall, flush_mask,
    output out_valid, out_data, occupancy, busy
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH pipeline registers, WIDTH data bits plus a valid bit each.
// Global stall holds every stage; flush_mask squashes individual stages
// (stage 0 youngest, stage DEPTH-1 oldest). Per-stage priority is
// rst > flush > stall > advance.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  slave side of pipe_stage_chain_if:
//        in_valid/in_data in, stall, flush_mask in,
//        out_valid/out_data from the oldest stage, occupancy (popcount of
//        valids), busy (any stage valid). All outputs come from registers.
module pipe_stage_chain #(
  parameter int               WIDTH               = 32,
  parameter int               DEPTH               = 1,
  parameter logic [WIDTH-1:0] RESET_VAL           = '0,
  parameter bit               CLEAR_DATA_ON_FLUSH = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  pipe_stage_chain_if.slave  bus
);
  localparam int OCC_W = ($clog2(DEPTH + 1) < 1) ? 1 : $clog2(DEPTH + 1);

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             v_q, v_d, src_v;
    logic [WIDTH-1:0] d_q, d_d, src_d;

    if (i == 0) begin : g_head
      assign src_v = bus.in_valid;
      assign src_d = bus.in_data;
    end else begin : g_link
      assign src_v = stage_valid[i-1];
      assign src_d = stage_data[i-1];
    end

    // Flush overrides stall; with CLEAR_DATA_ON_FLUSH=0 the data path
    // behaves as if no flush happened and only the valid bit drops.
    always_comb begin
      v_d = bus.stall ? v_q : src_v;
      d_d = bus.stall ? d_q : src_d;
      if (bus.flush_mask[i]) begin
        v_d = 1'b0;
        if (CLEAR_DATA_ON_FLUSH) d_d = RESET_VAL;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= RESET_VAL;
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    end

    assign stage_valid[i] = v_q;
    assign stage_data[i]  = d_q;
  end

  assign bus.out_valid = stage_valid[DEPTH-1];
  assign bus.out_data  = stage_data[DEPTH-1];
  assign bus.occupancy = OCC_W'($countones(stage_valid));
  assign bus.busy      = |stage_valid;
endmodule

// File: tb/tb_pipe_stage_chain.sv
module tb_pipe_stage_chain;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(3)) if3  ();
  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(3)) if3n ();
  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(2)) if2  ();
  pipe_stage_chain_if #(.WIDTH(32), .DEPTH(4)) if4  ();

  pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV), .CLEAR_DATA_ON_FLUSH(1'b1))
    u3 (.clk(clk), .rst(rst), .bus(if3));
  pipe_stage_chain #(.WIDTH(32), .DEPTH(3), .RESET_VAL(RV), .CLEAR_DATA_ON_FLUSH(1'b0))
    u3n (.clk(clk), .rst(rst), .bus(if3n));
  pipe_stage_chain #(.WIDTH(32), .DEPTH(2), .RESET_VAL(32'h0), .CLEAR_DATA_ON_FLUSH(1'b1))
    u2 (.clk(clk), .rst(rst), .bus(if2));
  pipe_stage_chain #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0), .CLEAR_DATA_ON_FLUSH(1'b1))
    u4 (.clk(clk), .rst(rst), .bus(if4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both DEPTH=3 chains receive identical stimulus.
  task automatic drv3(input logic v, input logic [31:0] d, input logic s, input logic [2:0] f);
    if3.in_valid = v;  if3.in_data = d;  if3.stall = s;  if3.flush_mask = f;
    if3n.in_valid = v; if3n.in_data = d; if3n.stall = s; if3n.flush_mask = f;
  endtask

  task automatic drv2(input logic v, input logic [31:0] d);
    if2.in_valid = v; if2.in_data = d; if2.stall = 1'b0; if2.flush_mask = 2'b00;
  endtask

  task automatic drv4(input logic v, input logic [31:0] d, input logic [3:0] f);
    if4.in_valid = v; if4.in_data = d; if4.stall = 1'b0; if4.flush_mask = f;
  endtask

  task automatic chk3(input string tag, input logic ov, input logic [31:0] od, input logic [1:0] occ);
    check({tag, "_ov"},  if3.out_valid, ov);
    check({tag, "_od"},  if3.out_data,  od);
    check({tag, "_occ"}, if3.occupancy, occ);
  endtask

  initial begin
    drv3(1'b0, 32'h0, 1'b0, 3'b000);
    drv2(1'b0, 32'h0);
    drv4(1'b0, 32'h0, 4'b0000);

    // Asynchronous reset asserted between edges.
    #3 rst = 1'b1;
    #1;
    chk3("rst_async", 1'b0, RV, 2'd0);
    check("rst_busy", if3.busy, 1'b0);
    check("rst_u4_busy", if4.busy, 1'b0);
    @(posedge clk);
    #3 rst = 1'b0;

    // Latency: word at edge k visible after edge k+2.
    drv3(1'b1, 32'd1, 1'b0, 3'b000); tick();
    check("lat1_ov", if3.out_valid, 1'b0); check("lat1_occ", if3.occupancy, 2'd1);
    drv3(1'b1, 32'd2, 1'b0, 3'b000); tick();
    check("lat2_ov", if3.out_valid, 1'b0); check("lat2_occ", if3.occupancy, 2'd2);
    drv3(1'b1, 32'd3, 1'b0, 3'b000); tick();
    chk3("lat3", 1'b1, 32'd1, 2'd3);
    drv3(1'b1, 32'd4, 1'b0, 3'b000); tick();
    chk3("lat4", 1'b1, 32'd2, 2'd3);
    drv3(1'b0, 32'd4, 1'b0, 3'b000); tick();
    chk3("lat5", 1'b1, 32'd3, 2'd2);
    tick();
    chk3("lat6", 1'b1, 32'd4, 2'd1);
    tick();
    check("lat7_ov", if3.out_valid, 1'b0); check("lat7_occ", if3.occupancy, 2'd0);
    check("lat7_busy", if3.busy, 1'b0);

    // Stall hold: stage2=12, stage1=11, stage0=10.
    drv3(1'b1, 32'd12, 1'b0, 3'b000); tick();
    drv3(1'b1, 32'd11, 1'b0, 3'b000); tick();
    drv3(1'b1, 32'd10, 1'b0, 3'b000); tick();
    chk3("stall_pre", 1'b1, 32'd12, 2'd3);
    drv3(1'b1, 32'd99, 1'b1, 3'b000);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk3("stall_hold", 1'b1, 32'd12, 2'd3);
    end
    drv3(1'b1, 32'd99, 1'b0, 3'b000); tick();
    chk3("stall_rel1", 1'b1, 32'd11, 2'd3);
    tick();
    chk3("stall_rel2", 1'b1, 32'd10, 2'd3);
    tick();
    chk3("stall_rel3", 1'b1, 32'd99, 2'd3);

    // Partial flush with advance: A(s2), B(s1), C(s0), D entering.
    drv3(1'b1, 32'hA, 1'b0, 3'b000); tick();
    drv3(1'b1, 32'hB, 1'b0, 3'b000); tick();
    drv3(1'b1, 32'hC, 1'b0, 3'b000); tick();
    chk3("pf_pre", 1'b1, 32'hA, 2'd3);
    drv3(1'b1, 32'hD, 1'b0, 3'b011); tick();
    chk3("pf_edge", 1'b1, 32'hB, 2'd1);
    check("pfn_edge_ov", if3n.out_valid, 1'b1);
    check("pfn_edge_od", if3n.out_data, 32'hB);
    check("pfn_edge_occ", if3n.occupancy, 2'd1);
    drv3(1'b0, 32'h0, 1'b0, 3'b000); tick();
    chk3("pf_s1", 1'b0, RV, 2'd0);
    check("pfn_s1_ov", if3n.out_valid, 1'b0);
    check("pfn_s1_od", if3n.out_data, 32'hC);
    tick();
    check("pf_s0_od", if3.out_data, RV);
    check("pfn_s0_ov", if3n.out_valid, 1'b0);
    check("pfn_s0_od", if3n.out_data, 32'hD);

    // Flush of the oldest stage during stall.
    drv3(1'b1, 32'd21, 1'b0, 3'b000); tick();
    drv3(1'b1, 32'd22, 1'b0, 3'b000); tick();
    drv3(1'b1, 32'd23, 1'b0, 3'b000); tick();
    chk3("fs_pre", 1'b1, 32'd21, 2'd3);
    drv3(1'b1, 32'h55, 1'b1, 3'b100); tick();
    chk3("fs_edge", 1'b0, RV, 2'd2);
    check("fsn_edge_ov", if3n.out_valid, 1'b0);
    check("fsn_edge_od", if3n.out_data, 32'd21);
    drv3(1'b0, 32'h0, 1'b0, 3'b000); tick();
    chk3("fs_rel1", 1'b1, 32'd22, 2'd2);
    tick();
    chk3("fs_rel2", 1'b1, 32'd23, 2'd1);

    // Bubble passage, DEPTH=2.
    drv2(1'b1, 32'd5); tick();
    check("bub1_ov", if2.out_valid, 1'b0); check("bub1_occ", if2.occupancy, 2'd1);
    drv2(1'b0, 32'd6); tick();
    check("bub2_ov", if2.out_valid, 1'b1); check("bub2_od", if2.out_data, 32'd5);
    check("bub2_occ", if2.occupancy, 2'd1);
    drv2(1'b1, 32'd7); tick();
    check("bub3_ov", if2.out_valid, 1'b0); check("bub3_od", if2.out_data, 32'd6);
    check("bub3_occ", if2.occupancy, 2'd1);
    drv2(1'b0, 32'd8); tick();
    check("bub4_ov", if2.out_valid, 1'b1); check("bub4_od", if2.out_data, 32'd7);
    drv2(1'b1, 32'd9); tick();
    check("bub5_occ", if2.occupancy, 2'd1);
    drv2(1'b1, 32'd10); tick();
    check("bub6_occ", if2.occupancy, 2'd2); check("bub6_od", if2.out_data, 32'd9);
    drv2(1'b1, 32'd11); tick();
    check("bub7_occ", if2.occupancy, 2'd2); check("bub7_od", if2.out_data, 32'd10);
    drv2(1'b0, 32'd0);

    // Full flush, DEPTH=4.
    for (int k = 1; k <= 6; k++) begin
      drv4(1'b1, 32'h30 + 32'(k), 4'b0000); tick();
    end
    check("ff_pre_occ", if4.occupancy, 3'd4);
    check("ff_pre_od", if4.out_data, 32'h33);
    drv4(1'b1, 32'h37, 4'b1111); tick();
    check("ff_occ", if4.occupancy, 3'd0);
    check("ff_busy", if4.busy, 1'b0);
    check("ff_ov", if4.out_valid, 1'b0);
    check("ff_od", if4.out_data, 32'h0);

    // Stream again, then asynchronous reset between edges.
    for (int k = 1; k <= 3; k++) begin
      drv4(1'b1, 32'h40 + 32'(k), 4'b0000); tick();
    end
    check("rs_pre_occ", if4.occupancy, 3'd3);
    check("rs_pre_busy", if4.busy, 1'b1);
    drv4(1'b0, 32'h0, 4'b0000);
    #3 rst = 1'b1;
    #1;
    check("rs_busy", if4.busy, 1'b0);
    check("rs_occ", if4.occupancy, 3'd0);
    @(posedge clk);
    #3 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("rs_post_ov", if4.out_valid, 1'b0);
      check("rs_post_busy", if4.busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
